// File: rtl/decode_stage_hz.sv
// Decode stage with ID/EX register: instruction decode, register file with write-back bypass,
// load-use hazard detection and saturating bubble/stall counters.
module decode_stage_hz #(
   parameter int XLEN      = 32,
   parameter bit WB_BYPASS = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             EnE,
   input  logic             FlushE,
   input  logic             ValidD,
   input  logic [31:0]      InstrD,
   input  logic [XLEN-1:0]  PCD,
   input  logic [XLEN-1:0]  PCPlus4D,
   input  logic             RegWriteW,
   input  logic [4:0]       RDW,
   input  logic [XLEN-1:0]  ResultW,
   output logic             MemWriteE,
   output logic             JalrE,
   output logic             ALUSrcE,
   output logic             RegWriteE,
   output logic             Op5E,
   output logic             JumpE,
   output logic             BranchE,
   output logic [1:0]       StoreE,
   output logic [1:0]       ResultSrcE,
   output logic [2:0]       LoadE,
   output logic [2:0]       funct3E,
   output logic [3:0]       ALUControlE,
   output logic [4:0]       RDE,
   output logic [4:0]       RS1E,
   output logic [4:0]       RS2E,
   output logic [XLEN-1:0]  RD1E,
   output logic [XLEN-1:0]  RD2E,
   output logic [XLEN-1:0]  ImmExtE,
   output logic [XLEN-1:0]  upimmE,
   output logic [XLEN-1:0]  PCE,
   output logic [XLEN-1:0]  PCPlus4E,
   output logic             ValidE,
   output logic             LoadStallD,
   output logic [CNT_W-1:0] BubbleCnt,
   output logic [CNT_W-1:0] StallCnt
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} immSel_e;

   typedef struct packed {
      logic            memWrite;
      logic            jalr;
      logic            aluSrc;
      logic            regWrite;
      logic            op5;
      logic            jump;
      logic            branch;
      logic [1:0]      store;
      logic [1:0]      resultSrc;
      logic [2:0]      load;
      logic [2:0]      funct3;
      logic [3:0]      aluCtl;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] immExt;
      logic [XLEN-1:0] upimm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pcPlus4;
      logic            valid;
   } eFields_t;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rs1, rs2, rd;
   logic            useRs1, useRs2;
   immSel_e         immSel;
   logic [31:0]     imm32, upimm32;
   logic [XLEN-1:0] rfRd1, rfRd2, rd1D, rd2D;
   logic [XLEN-1:0] regs_q [1:31];
   eFields_t        dec_d, e_d, e_q;
   logic            bubbleLoad, stallEvent;
   logic [CNT_W-1:0] bubbleCnt_q, stallCnt_q;

   assign opcode = InstrD[6:0];
   assign funct3 = InstrD[14:12];
   assign rs1    = InstrD[19:15];
   assign rs2    = InstrD[24:20];
   assign rd     = InstrD[11:7];

   assign useRs1 = (opcode == OP_LOAD) || (opcode == OP_IMM) || (opcode == OP_STORE) ||
                   (opcode == OP_REG) || (opcode == OP_BRANCH) || (opcode == OP_JALR);
   assign useRs2 = (opcode == OP_STORE) || (opcode == OP_REG) || (opcode == OP_BRANCH);

   // Register file; x0 is not stored and always reads zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < 32; i++) regs_q[i] <= '0;
      end else if (RegWriteW && (RDW != 5'd0)) begin
         regs_q[RDW] <= ResultW;
      end
   end

   assign rfRd1 = (rs1 == 5'd0) ? '0 : regs_q[rs1];
   assign rfRd2 = (rs2 == 5'd0) ? '0 : regs_q[rs2];
   assign rd1D  = (WB_BYPASS && RegWriteW && (RDW != 5'd0) && (RDW == rs1)) ? ResultW : rfRd1;
   assign rd2D  = (WB_BYPASS && RegWriteW && (RDW != 5'd0) && (RDW == rs2)) ? ResultW : rfRd2;

   always_comb begin
      imm32 = '0;
      case (immSel)
         IMM_I:   imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
         IMM_S:   imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B:   imm32 = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
         IMM_J:   imm32 = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
         IMM_U:   imm32 = {InstrD[31:12], 12'h000};
         default: imm32 = '0;
      endcase
   end

   assign upimm32 = {InstrD[31:12], 12'h000};

   // Controller: builds the full set of E-side fields for a real instruction.
   always_comb begin
      dec_d         = '0;
      immSel        = IMM_NONE;
      dec_d.op5     = InstrD[5];
      dec_d.funct3  = funct3;
      case (opcode)
         OP_LOAD: begin
            dec_d.regWrite = 1'b1; dec_d.aluSrc = 1'b1; dec_d.resultSrc = 2'b01;
            dec_d.load = funct3; immSel = IMM_I;
         end
         OP_STORE: begin
            dec_d.memWrite = 1'b1; dec_d.aluSrc = 1'b1;
            dec_d.store = funct3[1:0] + 2'd1; immSel = IMM_S;
         end
         OP_REG: begin
            dec_d.regWrite = 1'b1; dec_d.aluCtl = {InstrD[30], funct3};
         end
         OP_IMM: begin
            dec_d.regWrite = 1'b1; dec_d.aluSrc = 1'b1; immSel = IMM_I;
            dec_d.aluCtl = {(funct3 == 3'b101) & InstrD[30], funct3};
         end
         OP_BRANCH: begin
            dec_d.branch = 1'b1; dec_d.aluCtl = 4'b1000; immSel = IMM_B;
         end
         OP_JAL: begin
            dec_d.jump = 1'b1; dec_d.regWrite = 1'b1; dec_d.resultSrc = 2'b10; immSel = IMM_J;
         end
         OP_JALR: begin
            dec_d.jalr = 1'b1; dec_d.regWrite = 1'b1; dec_d.aluSrc = 1'b1;
            dec_d.resultSrc = 2'b10; immSel = IMM_I;
         end
         OP_LUI, OP_AUIPC: begin
            dec_d.regWrite = 1'b1; dec_d.aluSrc = 1'b1; dec_d.resultSrc = 2'b11; immSel = IMM_U;
         end
         default: ;
      endcase
      dec_d.rd      = rd;
      dec_d.rs1     = rs1;
      dec_d.rs2     = rs2;
      dec_d.rd1     = rd1D;
      dec_d.rd2     = rd2D;
      dec_d.immExt  = XLEN'($signed(imm32));
      dec_d.upimm   = XLEN'($signed(upimm32));
      dec_d.pc      = PCD;
      dec_d.pcPlus4 = PCPlus4D;
      dec_d.valid   = 1'b1;
   end

   assign LoadStallD = e_q.valid && e_q.regWrite && (e_q.resultSrc == 2'b01) && (e_q.rd != 5'd0) &&
                       ValidD && ((useRs1 && (e_q.rd == rs1)) || (useRs2 && (e_q.rd == rs2)));

   assign stallEvent = LoadStallD && EnE && !FlushE;

   // A flush outranks the enable, so a flushed bubble still lands while E is frozen.
   always_comb begin
      e_d        = e_q;
      bubbleLoad = 1'b0;
      if (FlushE) begin
         e_d        = '0;
         bubbleLoad = 1'b1;
      end else if (!EnE) begin
         e_d        = e_q;
      end else if (LoadStallD || !ValidD) begin
         e_d        = '0;
         bubbleLoad = 1'b1;
      end else begin
         e_d        = dec_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q         <= '0;
         bubbleCnt_q <= '0;
         stallCnt_q  <= '0;
      end else begin
         e_q <= e_d;
         if (bubbleLoad && (bubbleCnt_q != {CNT_W{1'b1}})) bubbleCnt_q <= bubbleCnt_q + CNT_W'(1);
         if (stallEvent && (stallCnt_q != {CNT_W{1'b1}}))  stallCnt_q  <= stallCnt_q + CNT_W'(1);
      end
   end

   assign MemWriteE   = e_q.memWrite;
   assign JalrE       = e_q.jalr;
   assign ALUSrcE     = e_q.aluSrc;
   assign RegWriteE   = e_q.regWrite;
   assign Op5E        = e_q.op5;
   assign JumpE       = e_q.jump;
   assign BranchE     = e_q.branch;
   assign StoreE      = e_q.store;
   assign ResultSrcE  = e_q.resultSrc;
   assign LoadE       = e_q.load;
   assign funct3E     = e_q.funct3;
   assign ALUControlE = e_q.aluCtl;
   assign RDE         = e_q.rd;
   assign RS1E        = e_q.rs1;
   assign RS2E        = e_q.rs2;
   assign RD1E        = e_q.rd1;
   assign RD2E        = e_q.rd2;
   assign ImmExtE     = e_q.immExt;
   assign upimmE      = e_q.upimm;
   assign PCE         = e_q.pc;
   assign PCPlus4E    = e_q.pcPlus4;
   assign ValidE      = e_q.valid;
   assign BubbleCnt   = bubbleCnt_q;
   assign StallCnt    = stallCnt_q;

endmodule

// File: doc/decode_stage_hz.md
# decode_stage_hz

Parametrised decode stage with an ID/EX pipeline register. It decodes InstrD through the team's controller, reg_file and imm_extend blocks and registers every execute-side field. It adds the execute-side stall/flush/valid handling and load-use hazard detection that the current decode stage lacks, plus write-back bypass and saturating hazard counters. It sits between the IF/ID register and the execute stage; the hazard unit drives EnE and FlushE and consumes LoadStallD.

## Interface
- XLEN, 32: data/PC width (32 or 64); instructions stay 32-bit.
- WB_BYPASS, 1: 1 = ResultW bypasses into RD1D/RD2D when RDW matches the source register.
- CNT_W, 16: width of each hazard counter.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- EnE  in  1  1 = E register may update; 0 = hold.
- FlushE  in  1  insert a bubble into E.
- ValidD  in  1  InstrD is a real instruction.
- InstrD  in  32  decoded instruction.
- PCD, PCPlus4D  in  XLEN  PC and PC+4 of InstrD.
- RegWriteW  in  1  write-back enable.
- RDW  in  5  write-back register.
- ResultW  in  XLEN  write-back data.
- MemWriteE, JalrE, ALUSrcE, RegWriteE, Op5E, JumpE, BranchE  out  1  registered controls.
- StoreE, ResultSrcE  out  2  registered controls.
- LoadE, funct3E  out  3  registered controls.
- ALUControlE  out  4  registered ALU op.
- RDE, RS1E, RS2E  out  5  registered register indices.
- RD1E, RD2E, ImmExtE, upimmE, PCE, PCPlus4E  out  XLEN  registered data; upimmE = sign-extended {InstrD[31:12],12'h0}.
- ValidE  out  1  E holds a real instruction.
- LoadStallD  out  1  combinational load-use hazard; upstream must freeze PC and IF/ID.
- BubbleCnt, StallCnt  out  CNT_W  saturating counters.

## Operation
- Source usage is decoded from InstrD[6:0]:
  - rs1 is used for opcodes 0000011, 0010011, 0100011, 0110011, 1100011 and 1100111.
  - rs2 is used for opcodes 0100011, 0110011 and 1100011.
- LoadStallD = ValidE & RegWriteE & (ResultSrcE==2'b01) & (RDE!=0) & ValidD & ((rs1 used & RDE==InstrD[19:15]) | (rs2 used & RDE==InstrD[24:20])).
- Bypass (WB_BYPASS=1): RD1D = ResultW when RegWriteW & RDW!=0 & RDW==InstrD[19:15]; otherwise the reg_file output. RD2D follows the same rule with rs2.
- x0 always reads 0, regardless of RegWriteW/RDW.
- E register update priority, evaluated each rising clk:
  1. reset: every E field and ValidE become 0; counters become 0.
  2. FlushE: bubble.
  3. !EnE: hold all fields.
  4. LoadStallD: bubble.
  5. !ValidD: bubble.
  6. Otherwise: load all decoded fields and set ValidE=1.
- Bubble: ValidE, RegWriteE, MemWriteE, JumpE, BranchE, JalrE = 0. All other fields also load 0, so bubbles are deterministic.
- BubbleCnt increments on every clock edge where a bubble is loaded (cases 2, 4 or 5). It saturates at 2^CNT_W−1.
- StallCnt increments on every edge with LoadStallD=1, EnE=1 and FlushE=0. It saturates at 2^CNT_W−1.
- upimmE, PCE and PCPlus4E are XLEN wide. For XLEN=64, upimmE is sign-extended from bit 31.

## Timing
- Latency: InstrD to E outputs is 1 cycle.
- LoadStallD depends combinationally on the current E contents and InstrD, in the same cycle.
- Reset is asynchronous: outputs go to 0 immediately on assertion, mid-operation included. The first update happens at the first clk edge after deassertion.
- FlushE and LoadStallD together: one bubble, BubbleCnt +1, StallCnt unchanged.
- EnE=0 with LoadStallD=1: E holds and LoadStallD stays asserted; no counter changes.
- Write-back and a decode read of the same register in the same cycle: with WB_BYPASS=1, E captures ResultW. With WB_BYPASS=0, E captures the old register value.
- Counters at saturation stay at all-ones.

## Test plan
- Reset: assert reset mid-stream with ValidE=1 → all outputs 0 asynchronously; first edge after release loads addi x5,x0,7 (0x00700293) → RegWriteE=1, ALUSrcE=1, RDE=5, ImmExtE=7, ValidE=1.
- Load-use: E holds lw x6,0(x1), D holds add x7,x6,x2 → LoadStallD=1; next edge gives ValidE=0, BubbleCnt=1, StallCnt=1. Same test with add x7,x2,x3 → LoadStallD=0.
- x0 and unused source: lw x0 followed by add using x0 → no stall. lw x6 followed by lui x6 → no stall, since lui does not use rs1.
- Bypass: RegWriteW=1, RDW=6, ResultW=0xDEADBEEF while D reads x6 → RD1E=0xDEADBEEF next cycle (WB_BYPASS=1). With RDW=0 → RD1E=0.
- Hold and flush: EnE=0 for 3 cycles → E unchanged. FlushE=1 together with EnE=0 → bubble loaded, BubbleCnt +1.
- Saturation: CNT_W=2, force 5 bubbles → BubbleCnt=3.
